reaction_trial_ctrl: RTL

//   Sequences one reaction-time trial: arm, random hold-off, GO lamp, capture button latency in ms.

---
 rtl/reaction_pkg.sv | 21 ++
 rtl/reaction_trial_ctrl_tick.sv | 26 ++
 rtl/reaction_trial_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/reaction_pkg.sv
// Shared constants for the reaction-time trial controller: FSM encodings, LFSR seed/taps, result codes.
package reaction_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARM    = 3'd1;
  localparam logic [2:0] S_DELAY  = 3'd2;
  localparam logic [2:0] S_GO     = 3'd3;
  localparam logic [2:0] S_REPORT = 3'd4;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 -> bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // All ones; the low CNT_W bits form the false-start code
  localparam logic [31:0] EARLY_CODE = '1;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/reaction_trial_ctrl_tick.sv
// Millisecond prescaler: counts 0..PRESCALE-1, pulses o_tick on the last count, clearable.
module ms_tick_gen #(
  parameter int PRESCALE = 10000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == CW'(PRESCALE - 1));
  assign o_tick = w_last;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)     r_cnt <= '0;
    else if (i_clr)   r_cnt <= '0;
    else if (w_last)  r_cnt <= '0;
    else              r_cnt <= r_cnt + CW'(1);
  end

endmodule

// File: rtl/reaction_trial_ctrl.sv
// One reaction-time trial: arm, random hold-off, GO lamp, latency capture, valid/ready result hand-off.
module reaction_trial_ctrl
  import reaction_pkg::*;
#(
  parameter int PRESCALE     = 10000,
  parameter int MIN_DELAY_MS = 1000,
  parameter int RAND_BITS    = 10,
  parameter int TIMEOUT_MS   = 2000,
  parameter int CNT_W        = 12
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_ena,
  input  logic             i_start,
  input  logic             i_btn,
  output logic             o_led_go,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_result_ms,
  output logic             o_result_early,
  output logic             o_result_tout,
  output logic             o_result_valid,
  input  logic             i_result_ready,
  output logic [2:0]       o_state_dbg
);

  localparam int DLY_W = $clog2(MIN_DELAY_MS + 2**RAND_BITS);

  logic [2:0]       r_state, w_nxt;
  logic [15:0]      r_lfsr;
  logic             r_start_q, r_btn_q;
  logic [DLY_W-1:0] r_dly;
  logic [CNT_W-1:0] r_ms;
  logic [CNT_W-1:0] r_result;
  logic             r_early, r_tout;

  logic w_start_rise, w_btn_rise, w_tick, w_clr;
  logic w_load_dly, w_go_entry, w_cap_early, w_cap_btn, w_cap_tout;

  assign w_start_rise = i_start & ~r_start_q;
  assign w_btn_rise   = i_btn & ~r_btn_q;
  assign w_clr        = w_load_dly | w_go_entry;

  ms_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_clr),
    .o_tick  (w_tick)
  );

  // State register plus the datapath it sequences
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_lfsr    <= LFSR_SEED;
      r_start_q <= 1'b0;
      r_btn_q   <= 1'b0;
      r_dly     <= '0;
      r_ms      <= '0;
      r_result  <= '0;
      r_early   <= 1'b0;
      r_tout    <= 1'b0;
    end else begin
      r_state   <= w_nxt;
      r_lfsr    <= lfsr_step(r_lfsr);
      r_start_q <= i_start;
      r_btn_q   <= i_btn;

      if (w_load_dly)
        r_dly <= DLY_W'(MIN_DELAY_MS) + DLY_W'(r_lfsr[RAND_BITS-1:0]);
      else if (r_state == S_DELAY && w_tick && r_dly != '0)
        r_dly <= r_dly - DLY_W'(1);

      if (w_go_entry)                   r_ms <= '0;
      else if (r_state == S_GO && w_tick) r_ms <= r_ms + CNT_W'(1);

      if (w_cap_early) begin
        r_result <= EARLY_CODE[CNT_W-1:0];
        r_early  <= 1'b1;
        r_tout   <= 1'b0;
      end else if (w_cap_btn) begin
        r_result <= r_ms;
        r_early  <= 1'b0;
        r_tout   <= 1'b0;
      end else if (w_cap_tout) begin
        r_result <= CNT_W'(TIMEOUT_MS);
        r_early  <= 1'b0;
        r_tout   <= 1'b1;
      end
    end
  end

  // Next state; btn rise outranks expiry/timeout, ena low overrides everything
  always_comb begin
    w_nxt       = r_state;
    w_load_dly  = 1'b0;
    w_go_entry  = 1'b0;
    w_cap_early = 1'b0;
    w_cap_btn   = 1'b0;
    w_cap_tout  = 1'b0;
    case (r_state)
      S_IDLE:   if (w_start_rise) w_nxt = S_ARM;
      S_ARM:    if (!i_btn) begin w_load_dly = 1'b1; w_nxt = S_DELAY; end
      S_DELAY:
        if (w_btn_rise)          begin w_cap_early = 1'b1; w_nxt = S_REPORT; end
        else if (r_dly == '0)    begin w_go_entry  = 1'b1; w_nxt = S_GO;     end
      S_GO:
        if (w_btn_rise)          begin w_cap_btn  = 1'b1; w_nxt = S_REPORT; end
        else if (r_ms == CNT_W'(TIMEOUT_MS))
                                 begin w_cap_tout = 1'b1; w_nxt = S_REPORT; end
      S_REPORT: if (i_result_ready) w_nxt = S_IDLE;
      default:  w_nxt = S_IDLE;
    endcase
    if (!i_ena) begin
      w_nxt       = S_IDLE;
      w_load_dly  = 1'b0;
      w_go_entry  = 1'b0;
      w_cap_early = 1'b0;
      w_cap_btn   = 1'b0;
      w_cap_tout  = 1'b0;
    end
  end

  always_comb begin
    o_led_go       = (r_state == S_GO);
    o_busy         = (r_state != S_IDLE);
    o_result_valid = (r_state == S_REPORT);
    o_result_ms    = r_result;
    o_result_early = r_early;
    o_result_tout  = r_tout;
    o_state_dbg    = r_state;
  end

endmodule
